// File: rtl/step_round_sched.sv
// Round/step sequencer: launches NUM_STEPS step units per round for NUM_ROUNDS rounds,
// ping-ponging the bank selector after each completed step, with a per-step timeout.
module step_round_sched #(
    parameter int unsigned NUM_STEPS  = 5,
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       step_done,
    output logic       step_start,
    output logic [2:0] step_sel,
    output logic [4:0] round_idx,
    output logic       bank_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StAdvance,
        StFinish,
        StError
    } state_e;

    localparam logic [2:0]  LAST_STEP  = 3'(NUM_STEPS - 1);
    localparam logic [4:0]  LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [11:0] TMO_LAST   = 12'(TIMEOUT - 1);

    state_e      state_q;
    logic [11:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            step_sel  <= '0;
            round_idx <= '0;
            bank_sel  <= 1'b0;
            err       <= 1'b0;
            tmo_cnt_q <= '0;
        end else if (abort && (state_q != StIdle)) begin
            // Abort wins over step_done and timeout; err keeps its value.
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        step_sel  <= '0;
                        round_idx <= '0;
                        bank_sel  <= 1'b0;
                        err       <= 1'b0;
                        state_q   <= StLaunch;
                    end
                end
                StLaunch: begin
                    tmo_cnt_q <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    // Toggling here makes the new bank visible during ADVANCE.
                    if (step_done) begin
                        bank_sel <= ~bank_sel;
                        state_q  <= StAdvance;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err     <= 1'b1;
                        state_q <= StError;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 12'd1;
                    end
                end
                StAdvance: begin
                    if (step_sel != LAST_STEP) begin
                        step_sel <= step_sel + 3'd1;
                        state_q  <= StLaunch;
                    end else if (round_idx != LAST_ROUND) begin
                        step_sel  <= '0;
                        round_idx <= round_idx + 5'd1;
                        state_q   <= StLaunch;
                    end else begin
                        state_q <= StFinish;
                    end
                end
                StFinish: state_q <= StIdle;
                StError:  state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        step_start = (state_q == StLaunch);
        done       = (state_q == StFinish);
        busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_step_round_sched.sv
// Directed bench for step_round_sched: a default-parameter instance plus a TIMEOUT=10
// instance sharing the same stimulus.
module tb_step_round_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       step_done;
    logic       step_start;
    logic [2:0] step_sel;
    logic [4:0] round_idx;
    logic       bank_sel;
    logic       busy;
    logic       done;
    logic       err;

    logic       to_step_start;
    logic [2:0] to_step_sel;
    logic [4:0] to_round_idx;
    logic       to_bank_sel;
    logic       to_busy;
    logic       to_done;
    logic       to_err;

    int nvec  = 0;
    int nfail = 0;
    int n_launch = 0;
    int n_done = 0;
    int to_n_done = 0;
    logic exp_bank;

    step_round_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .step_done  (step_done),
        .step_start (step_start),
        .step_sel   (step_sel),
        .round_idx  (round_idx),
        .bank_sel   (bank_sel),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    step_round_sched #(
        .TIMEOUT (10)
    ) dut_to (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .step_done  (step_done),
        .step_start (to_step_start),
        .step_sel   (to_step_sel),
        .round_idx  (to_round_idx),
        .bank_sel   (to_bank_sel),
        .busy       (to_busy),
        .done       (to_done),
        .err        (to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (step_start) n_launch++;
        if (done) n_done++;
        if (to_done) to_n_done++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the LAUNCH cycle; leaves in the cycle after ADVANCE.
    task automatic run_step(input int s, input int r);
        check_eq("launch", 32'(step_start), 1);
        check_eq("step_sel", 32'(step_sel), 32'(s));
        check_eq("round_idx", 32'(round_idx), 32'(r));
        check_eq("bank_rd", 32'(bank_sel), 32'(exp_bank));
        tick();
        tick();
        tick();
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        exp_bank = ~exp_bank;
        check_eq("adv_bank", 32'(bank_sel), 32'(exp_bank));
        check_eq("adv_no_launch", 32'(step_start), 0);
        tick();
    endtask

    task automatic run_job();
        int base_l;
        int base_d;
        base_l = n_launch;
        base_d = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_bank = 1'b0;
        for (int r = 0; r < 24; r++) begin
            for (int s = 0; s < 5; s++) begin
                run_step(s, r);
            end
        end
        check_eq("fin_done", 32'(done), 1);
        check_eq("fin_busy", 32'(busy), 1);
        check_eq("fin_step", 32'(step_sel), 4);
        check_eq("fin_round", 32'(round_idx), 23);
        check_eq("fin_bank", 32'(bank_sel), 0);
        check_eq("fin_err", 32'(err), 0);
        tick();
        check_eq("post_done", 32'(done), 0);
        check_eq("post_busy", 32'(busy), 0);
        check_eq("job_launches", 32'(n_launch - base_l), 120);
        check_eq("job_dones", 32'(n_done - base_d), 1);
    endtask

    initial begin
        int snap_l;
        int snap_d;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        step_done = 1'b0;
        tick();
        tick();
        check_eq("rst_step_start", 32'(step_start), 0);
        check_eq("rst_step_sel", 32'(step_sel), 0);
        check_eq("rst_round", 32'(round_idx), 0);
        check_eq("rst_bank", 32'(bank_sel), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        rst = 1'b1;
        tick();

        // Full job with default parameters.
        run_job();

        // Timeout on the TIMEOUT=10 instance.
        snap_d = to_n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("to_launch", 32'(to_step_start), 1);
        for (int i = 0; i < 10; i++) tick();
        check_eq("to_wait10_busy", 32'(to_busy), 1);
        check_eq("to_wait10_err", 32'(to_err), 0);
        tick();
        check_eq("to_error_busy", 32'(to_busy), 1);
        tick();
        check_eq("to_idle_busy", 32'(to_busy), 0);
        check_eq("to_idle_err", 32'(to_err), 1);
        check_eq("to_no_done", 32'(to_n_done - snap_d), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("to_err_cleared", 32'(to_err), 0);
        check_eq("to_relaunch", 32'(to_step_start), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_to_busy", 32'(to_busy), 0);

        // Abort at round 5 step 2, coincident with step_done.
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_bank = 1'b0;
        for (int k = 0; k < 27; k++) run_step(k % 5, k / 5);
        check_eq("ab_step", 32'(step_sel), 2);
        check_eq("ab_round", 32'(round_idx), 5);
        tick();
        tick();
        tick();
        snap_d = n_done;
        step_done = 1'b1;
        abort = 1'b1;
        tick();
        step_done = 1'b0;
        abort = 1'b0;
        check_eq("ab_busy", 32'(busy), 0);
        check_eq("ab_no_adv_bank", 32'(bank_sel), 1);
        check_eq("ab_done", 32'(done), 0);
        check_eq("ab_err", 32'(err), 0);
        tick();
        tick();
        check_eq("ab_no_launch", 32'(step_start), 0);
        check_eq("ab_no_done_cnt", 32'(n_done - snap_d), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ab_restart_launch", 32'(step_start), 1);
        check_eq("ab_restart_step", 32'(step_sel), 0);
        check_eq("ab_restart_round", 32'(round_idx), 0);
        check_eq("ab_restart_bank", 32'(bank_sel), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Spurious step_done in IDLE and LAUNCH, start while busy.
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check_eq("sp_idle_busy", 32'(busy), 0);
        check_eq("sp_idle_launch", 32'(step_start), 0);
        start = 1'b1;
        tick();
        check_eq("sp_launch", 32'(step_start), 1);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check_eq("sp_wait_busy", 32'(busy), 1);
        check_eq("sp_wait_no_launch", 32'(step_start), 0);
        check_eq("sp_wait_bank", 32'(bank_sel), 0);
        snap_l = n_launch;
        tick();
        tick();
        start = 1'b0;
        tick();
        check_eq("sp_busy_start_launch", 32'(n_launch - snap_l), 0);
        check_eq("sp_busy_start_sel", 32'(step_sel), 0);
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        check_eq("sp_adv_bank", 32'(bank_sel), 1);
        tick();
        check_eq("sp_next_launch", 32'(step_start), 1);
        check_eq("sp_next_step", 32'(step_sel), 1);

        // Reset in WAIT at round 12, with start and step_done also asserted.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_bank = 1'b0;
        for (int k = 0; k < 60; k++) run_step(k % 5, k / 5);
        check_eq("rw_round", 32'(round_idx), 12);
        tick();
        tick();
        snap_l = n_launch;
        snap_d = n_done;
        rst = 1'b0;
        start = 1'b1;
        step_done = 1'b1;
        tick();
        rst = 1'b1;
        start = 1'b0;
        step_done = 1'b0;
        check_eq("rw_step_start", 32'(step_start), 0);
        check_eq("rw_step_sel", 32'(step_sel), 0);
        check_eq("rw_round0", 32'(round_idx), 0);
        check_eq("rw_bank", 32'(bank_sel), 0);
        check_eq("rw_busy", 32'(busy), 0);
        check_eq("rw_done", 32'(done), 0);
        check_eq("rw_err", 32'(err), 0);
        tick();
        tick();
        check_eq("rw_no_launch", 32'(n_launch - snap_l), 0);
        check_eq("rw_no_done", 32'(n_done - snap_d), 0);
        run_job();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/step_round_sched.md
STEP_ROUND_SCHED -- requirements
Module: step_round_sched

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 5: step units sequenced per round (1..8).
REQ-002 SHALL have parameter NUM_ROUNDS, default 24: rounds per job (1..32).
REQ-003 SHALL have parameter TIMEOUT, default 4095: maximum cycles spent in WAIT before the error path is taken (1..4095).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low; sampled only on clk rising edge.
REQ-006 SHALL have port start, input, 1 bit: job request; honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: cancel the current job.
REQ-008 SHALL have port step_done, input, 1 bit: completion pulse from the selected step unit.
REQ-009 SHALL have port step_start, output, 1 bit: one-cycle launch pulse to the selected step unit.
REQ-010 SHALL have port step_sel, output, 3 bits: index of the active step unit.
REQ-011 SHALL have port round_idx, output, 5 bits: current round number.
REQ-012 SHALL have port bank_sel, output, 1 bit: ping-pong selector; the step reads bank bank_sel and writes bank ~bank_sel.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking normal job completion.
REQ-015 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-016 SHALL implement the states IDLE, LAUNCH, WAIT, ADVANCE, FINISH and ERROR; all outputs are registered or decoded from registered state only.
REQ-017 SHALL, in IDLE with start=1 on an edge, clear step_sel, round_idx, bank_sel and err, then enter LAUNCH.
REQ-018 SHALL drive step_start=1 for exactly the one cycle spent in LAUNCH, then enter WAIT.
REQ-019 SHALL, in WAIT, increment the timeout counter every cycle and clear it on entry to WAIT.
REQ-020 SHALL, in WAIT with step_done=1, enter ADVANCE; if the counter reaches TIMEOUT with no step_done, it SHALL enter ERROR instead.
REQ-021 SHALL, in ADVANCE, toggle bank_sel.
REQ-022 SHALL, in ADVANCE when step_sel<NUM_STEPS-1, increment step_sel and go to LAUNCH.
REQ-023 SHALL, in ADVANCE when step_sel=NUM_STEPS-1 and round_idx<NUM_ROUNDS-1, wrap step_sel to 0, increment round_idx and go to LAUNCH.
REQ-024 SHALL, in ADVANCE when step_sel=NUM_STEPS-1 and round_idx=NUM_ROUNDS-1, go to FINISH without changing step_sel or round_idx.
REQ-025 SHALL drive done=1 for exactly the one cycle spent in FINISH, then return to IDLE; step_sel, round_idx and bank_sel hold their values.
REQ-026 SHALL give the following latencies: step_done sampled at edge N gives ADVANCE in cycle N+1 and the next step_start (or done) in cycle N+2; start sampled at edge N gives step_start in cycle N+1.
REQ-027 SHALL, in ERROR, set err=1 and return to IDLE the next cycle without asserting done; err stays high until the next accepted start or reset.
REQ-028 SHALL ignore step_done in any state other than WAIT.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL, when abort=1 on an edge in any non-IDLE state, enter IDLE next with done=0 and err unchanged; abort in IDLE has no effect.
REQ-031 SHALL give abort priority over step_done and timeout when they coincide on the same edge.
REQ-032 SHALL give priority to step_done over timeout when both occur on the same edge, so the job proceeds normally.

Reset
REQ-033 SHALL, with rst=0 on an edge, force state IDLE and step_start=0, step_sel=0, round_idx=0, bank_sel=0, busy=0, done=0, err=0, timeout counter=0, regardless of state.
REQ-034 SHALL let reset override start, abort and step_done; a reset mid-job discards the job, produces no done pulse and leaves no pending launch.

Verification
REQ-035 Full job, defaults, step_done returned 3 cycles after each step_start -> 120 step_start pulses, step_sel sequence 0..4 repeated, round_idx ends at 23, bank_sel ends at 0, exactly one done pulse, err=0.
REQ-036 Latency: step_done pulse sampled at edge N -> bank_sel toggles in cycle N+1, next step_start in cycle N+2, and on the final step done in cycle N+2.
REQ-037 Timeout: TIMEOUT=10, step_done never returned -> ERROR after 10 WAIT cycles, err=1, busy=0, no done pulse; the next start clears err.
REQ-038 Abort during round 5 step 2, coincident with step_done -> IDLE next cycle, no ADVANCE, done=0, err unchanged; a fresh start restarts at round 0 step 0 with bank_sel=0.
REQ-039 Spurious inputs: step_done in IDLE or LAUNCH, and start while busy -> no state change, no extra step_start.
REQ-040 Reset (rst=0) asserted in WAIT at round 12 -> all outputs at their reset values next cycle; a subsequent start runs a complete normal job.
